// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory port bundle for mem_port_arbiter
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;

  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        stall_if;
  logic        stall_pipe;
  logic        proto_err;

  // slave is the arbiter's view; master is the pipeline-plus-memory side
  modport slave (
    input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr,
           mem_wdata, stall_if, stall_pipe, proto_err
  );

  modport master (
    output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr,
           mem_wdata, stall_if, stall_pipe, proto_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and data access
module mem_port_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] LP_LAT = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        r_last_dm;
  logic        w_last_dm_nxt;
  logic        r_is_store;
  logic        r_proto_err;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_if_rdata;
  logic [31:0] r_dm_rdata;

  logic        w_dm_pend;
  logic        w_grant_if;
  logic        w_grant_dm;
  logic        w_grant;
  logic        w_if_ack;
  logic        w_dm_ack;
  logic [31:0] w_mem_addr;
  logic [31:0] w_mem_wdata;

  assign w_dm_pend = bus.dm_read | bus.dm_write;

  // Grants are combinational in IDLE so the access starts in the request cycle;
  // reset masks them because the state register alone cannot hide live requests.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_last_dm_nxt = r_last_dm;
    w_grant_if    = 1'b0;
    w_grant_dm    = 1'b0;
    w_if_ack      = 1'b0;
    w_dm_ack      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!reset) begin
          if (w_dm_pend && (!bus.if_req || !r_last_dm)) begin
            w_grant_dm    = 1'b1;
            w_state_nxt   = DM_BUSY;
            w_cnt_nxt     = LP_LAT;
            w_last_dm_nxt = 1'b1;
          end else if (bus.if_req) begin
            w_grant_if    = 1'b1;
            w_state_nxt   = IF_BUSY;
            w_cnt_nxt     = LP_LAT;
            w_last_dm_nxt = 1'b0;
          end
        end
      end
      IF_BUSY: begin
        if (r_cnt == 4'd1) begin
          w_if_ack    = 1'b1;
          w_state_nxt = IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      DM_BUSY: begin
        if (r_cnt == 4'd1) begin
          w_dm_ack    = 1'b1;
          w_state_nxt = IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign w_grant     = w_grant_if | w_grant_dm;
  assign w_mem_addr  = w_grant_dm ? bus.dm_addr :
                       w_grant_if ? bus.if_addr : r_mem_addr;
  assign w_mem_wdata = w_grant_dm ? bus.dm_wdata : r_mem_wdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_last_dm   <= 1'b0;
      r_is_store  <= 1'b0;
      r_proto_err <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_if_rdata  <= 32'd0;
      r_dm_rdata  <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_last_dm <= w_last_dm_nxt;
      if (w_grant) begin
        r_mem_addr <= w_mem_addr;
      end
      if (w_grant_dm) begin
        r_mem_wdata <= bus.dm_wdata;
        r_is_store  <= bus.dm_write;
        if (bus.dm_read && bus.dm_write) begin
          r_proto_err <= 1'b1;
        end
      end
      if (w_if_ack) begin
        r_if_rdata <= bus.mem_rdata;
      end
      if (w_dm_ack && !r_is_store) begin
        r_dm_rdata <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_en     = w_grant;
  assign bus.mem_we     = w_grant_dm & bus.dm_write;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_wdata  = w_mem_wdata;
  assign bus.if_ack     = w_if_ack;
  assign bus.dm_ack     = w_dm_ack;
  // Read data is forwarded in the completion cycle and held from the register after it.
  assign bus.if_rdata   = w_if_ack ? bus.mem_rdata : r_if_rdata;
  assign bus.dm_rdata   = (w_dm_ack && !r_is_store) ? bus.mem_rdata : r_dm_rdata;
  assign bus.stall_if   = !reset & bus.if_req & !w_if_ack;
  assign bus.stall_pipe = !reset & w_dm_pend & !w_dm_ack;
  assign bus.proto_err  = r_proto_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.LATENCY(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // {mem_en, mem_we, if_ack, dm_ack, stall_if, stall_pipe, proto_err}
  logic [6:0] w_flags;
  assign w_flags = {bus.mem_en, bus.mem_we, bus.if_ack, bus.dm_ack,
                    bus.stall_if, bus.stall_pipe, bus.proto_err};

  task automatic test_reset();
    reset         = 1'b1;
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h0000_0004;
    bus.dm_read   = 1'b1;
    bus.dm_write  = 1'b0;
    bus.dm_addr   = 32'h0000_0008;
    bus.dm_wdata  = 32'h0;
    bus.mem_rdata = 32'h0;
    @(negedge clock);
    total++; if (w_flags !== 7'b0) begin bad++; $display("FAIL reset_flags got=%b exp=%b", w_flags, 7'b0); end
    total++; if (bus.if_rdata !== 32'h0) begin bad++; $display("FAIL reset_if_rdata got=%h exp=%h", bus.if_rdata, 32'h0); end
    total++; if (bus.dm_rdata !== 32'h0) begin bad++; $display("FAIL reset_dm_rdata got=%h exp=%h", bus.dm_rdata, 32'h0); end
    total++; if (bus.mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=%h", bus.mem_addr, 32'h0); end
    total++; if (bus.mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_wdata got=%h exp=%h", bus.mem_wdata, 32'h0); end
    @(posedge clock); #1;
    bus.if_req  = 1'b0;
    bus.dm_read = 1'b0;
    reset       = 1'b0;
    @(negedge clock);
    total++; if (w_flags !== 7'b0) begin bad++; $display("FAIL reset_idle_flags got=%b exp=%b", w_flags, 7'b0); end
  endtask

  task automatic test_fetch();
    logic [6:0] ef [4] = '{7'b1000100, 7'b0000100, 7'b0010000, 7'b0000000};
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      case (c)
        0: begin bus.if_req = 1'b1; bus.if_addr = 32'h40; bus.mem_rdata = 32'h0; end
        2: bus.mem_rdata = 32'h8C22_0004;
        3: begin bus.if_req = 1'b0; bus.mem_rdata = 32'hFFFF_FFFF; end
        default: ;
      endcase
      @(negedge clock);
      total++; if (w_flags !== ef[c]) begin bad++; $display("FAIL fetch_flags c%0d got=%b exp=%b", c, w_flags, ef[c]); end
      if (c < 2) begin
        total++; if (bus.mem_addr !== 32'h40) begin bad++; $display("FAIL fetch_addr c%0d got=%h exp=%h", c, bus.mem_addr, 32'h40); end
      end else begin
        total++; if (bus.if_rdata !== 32'h8C22_0004) begin bad++; $display("FAIL fetch_rdata c%0d got=%h exp=%h", c, bus.if_rdata, 32'h8C22_0004); end
      end
    end
  endtask

  task automatic test_arbitration();
    logic [6:0]  ef [7] = '{7'b1000110, 7'b0000110, 7'b0001100, 7'b1000100,
                            7'b0000100, 7'b0010000, 7'b0000000};
    for (int c = 0; c < 7; c++) begin
      @(posedge clock); #1;
      case (c)
        0: begin
          bus.if_req  = 1'b1; bus.if_addr = 32'h100;
          bus.dm_read = 1'b1; bus.dm_addr = 32'h200;
        end
        2: bus.mem_rdata = 32'h1111_0000;
        3: begin bus.dm_read = 1'b0; bus.mem_rdata = 32'hDEAD_0000; end
        5: bus.mem_rdata = 32'h2222_0000;
        6: bus.if_req = 1'b0;
        default: ;
      endcase
      @(negedge clock);
      total++; if (w_flags !== ef[c]) begin bad++; $display("FAIL arb_flags c%0d got=%b exp=%b", c, w_flags, ef[c]); end
      if (c == 0) begin
        total++; if (bus.mem_addr !== 32'h200) begin bad++; $display("FAIL arb_first_addr got=%h exp=%h", bus.mem_addr, 32'h200); end
      end
      if (c == 3) begin
        total++; if (bus.mem_addr !== 32'h100) begin bad++; $display("FAIL arb_second_addr got=%h exp=%h", bus.mem_addr, 32'h100); end
      end
      if (c == 5) begin
        total++; if (bus.if_rdata !== 32'h2222_0000) begin bad++; $display("FAIL arb_if_rdata got=%h exp=%h", bus.if_rdata, 32'h2222_0000); end
      end
      if (c >= 2) begin
        total++; if (bus.dm_rdata !== 32'h1111_0000) begin bad++; $display("FAIL arb_dm_rdata c%0d got=%h exp=%h", c, bus.dm_rdata, 32'h1111_0000); end
      end
    end
  endtask

  task automatic test_store();
    logic [6:0] ef [4] = '{7'b1100010, 7'b0000010, 7'b0001000, 7'b0000000};
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      case (c)
        0: begin
          bus.dm_write = 1'b1; bus.dm_addr = 32'h10;
          bus.dm_wdata = 32'hDEAD_BEEF; bus.mem_rdata = 32'h0;
        end
        2: bus.mem_rdata = 32'hAAAA_AAAA;
        3: bus.dm_write = 1'b0;
        default: ;
      endcase
      @(negedge clock);
      total++; if (w_flags !== ef[c]) begin bad++; $display("FAIL store_flags c%0d got=%b exp=%b", c, w_flags, ef[c]); end
      if (c < 2) begin
        total++; if (bus.mem_addr !== 32'h10) begin bad++; $display("FAIL store_addr c%0d got=%h exp=%h", c, bus.mem_addr, 32'h10); end
        total++; if (bus.mem_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL store_wdata c%0d got=%h exp=%h", c, bus.mem_wdata, 32'hDEAD_BEEF); end
      end else begin
        total++; if (bus.dm_rdata !== 32'h1111_0000) begin bad++; $display("FAIL store_dm_rdata c%0d got=%h exp=%h", c, bus.dm_rdata, 32'h1111_0000); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ef [3] = '{7'b1000110, 7'b0000110, 7'b0010010};
    logic [6:0] ed [3] = '{7'b1000110, 7'b0000110, 7'b0001100};
    logic [6:0] exp_f;
    logic [31:0] exp_a;
    for (int c = 0; c < 13; c++) begin
      @(posedge clock); #1;
      if (c == 0) begin
        bus.if_req  = 1'b1; bus.if_addr = 32'h300;
        bus.dm_read = 1'b1; bus.dm_addr = 32'h400;
        bus.mem_rdata = 32'h3333_0000;
      end
      if (c == 12) begin bus.if_req = 1'b0; bus.dm_read = 1'b0; end
      @(negedge clock);
      // previous grant was data, so fetch leads: fetch, data, fetch, data
      exp_f = (c == 12) ? 7'b0 : (((c / 3) % 2) == 0) ? ef[c % 3] : ed[c % 3];
      exp_a = (((c / 3) % 2) == 0) ? 32'h300 : 32'h400;
      total++; if (w_flags !== exp_f) begin bad++; $display("FAIL b2b_flags c%0d got=%b exp=%b", c, w_flags, exp_f); end
      if ((c % 3) == 0 && c < 12) begin
        total++; if (bus.mem_addr !== exp_a) begin bad++; $display("FAIL b2b_addr c%0d got=%h exp=%h", c, bus.mem_addr, exp_a); end
      end
    end
    total++; if (bus.dm_rdata !== 32'h3333_0000) begin bad++; $display("FAIL b2b_dm_rdata got=%h exp=%h", bus.dm_rdata, 32'h3333_0000); end
  endtask

  task automatic test_proto_err();
    logic [6:0] ef [6] = '{7'b1100010, 7'b0000011, 7'b0001001, 7'b0000001,
                           7'b0000001, 7'b0000001};
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      case (c)
        0: begin
          bus.dm_read = 1'b1; bus.dm_write = 1'b1; bus.dm_addr = 32'h20;
          bus.dm_wdata = 32'h5A5A_5A5A; bus.mem_rdata = 32'h7777_7777;
        end
        3: begin bus.dm_read = 1'b0; bus.dm_write = 1'b0; end
        default: ;
      endcase
      @(negedge clock);
      total++; if (w_flags !== ef[c]) begin bad++; $display("FAIL perr_flags c%0d got=%b exp=%b", c, w_flags, ef[c]); end
      if (c == 0) begin
        total++; if (bus.mem_wdata !== 32'h5A5A_5A5A) begin bad++; $display("FAIL perr_wdata got=%h exp=%h", bus.mem_wdata, 32'h5A5A_5A5A); end
      end
      if (c == 2) begin
        total++; if (bus.dm_rdata !== 32'h3333_0000) begin bad++; $display("FAIL perr_dm_rdata got=%h exp=%h", bus.dm_rdata, 32'h3333_0000); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] ef [7] = '{7'b1000011, 7'b0000000, 7'b0000000, 7'b1000010,
                           7'b0000010, 7'b0001000, 7'b0000000};
    for (int c = 0; c < 7; c++) begin
      @(posedge clock); #1;
      case (c)
        0: begin bus.dm_read = 1'b1; bus.dm_addr = 32'h44; bus.mem_rdata = 32'h9999_9999; end
        1: reset = 1'b1;
        3: reset = 1'b0;
        6: bus.dm_read = 1'b0;
        default: ;
      endcase
      @(negedge clock);
      total++; if (w_flags !== ef[c]) begin bad++; $display("FAIL rmid_flags c%0d got=%b exp=%b", c, w_flags, ef[c]); end
      if (c == 1) begin
        total++; if (bus.dm_rdata !== 32'h0) begin bad++; $display("FAIL rmid_dm_rdata got=%h exp=%h", bus.dm_rdata, 32'h0); end
        total++; if (bus.if_rdata !== 32'h0) begin bad++; $display("FAIL rmid_if_rdata got=%h exp=%h", bus.if_rdata, 32'h0); end
        total++; if (bus.mem_addr !== 32'h0) begin bad++; $display("FAIL rmid_mem_addr got=%h exp=%h", bus.mem_addr, 32'h0); end
      end
      if (c == 3) begin
        total++; if (bus.mem_addr !== 32'h44) begin bad++; $display("FAIL rmid_regrant_addr got=%h exp=%h", bus.mem_addr, 32'h44); end
      end
      if (c == 5) begin
        total++; if (bus.dm_rdata !== 32'h9999_9999) begin bad++; $display("FAIL rmid_new_rdata got=%h exp=%h", bus.dm_rdata, 32'h9999_9999); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_arbitration();
    test_store();
    test_back_to_back();
    test_proto_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2, meaning cycles from grant to memory read data valid; legal range 1..15.
REQ-002 The block SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port if_req  input  1  instruction-fetch request, held until if_ack.
REQ-005 The block SHALL have port if_addr  input  32  fetch byte address.
REQ-006 The block SHALL have port if_rdata  output  32  fetched instruction word.
REQ-007 The block SHALL have port if_ack  output  1  one-cycle fetch completion pulse.
REQ-008 The block SHALL have port dm_read  input  1  data load request, held until dm_ack.
REQ-009 The block SHALL have port dm_write  input  1  data store request, held until dm_ack.
REQ-010 The block SHALL have port dm_addr  input  32  data byte address.
REQ-011 The block SHALL have port dm_wdata  input  32  store data.
REQ-012 The block SHALL have port dm_rdata  output  32  load data.
REQ-013 The block SHALL have port dm_ack  output  1  one-cycle data completion pulse.
REQ-014 The block SHALL have port mem_en  output  1  single-port memory access strobe.
REQ-015 The block SHALL have port mem_we  output  1  memory write enable.
REQ-016 The block SHALL have port mem_addr  output  32  memory address.
REQ-017 The block SHALL have port mem_wdata  output  32  memory write data.
REQ-018 The block SHALL have port mem_rdata  input  32  memory read data, valid exactly LATENCY cycles after mem_en.
REQ-019 The block SHALL have port stall_if  output  1  freeze PC and IF/ID.
REQ-020 The block SHALL have port stall_pipe  output  1  freeze all pipeline registers up to and including EXE/MEM.
REQ-021 The block SHALL have port proto_err  output  1  sticky protocol-error flag.

Function
REQ-022 FSM states SHALL be IDLE, IF_BUSY, DM_BUSY; one access outstanding at most.
REQ-023 In IDLE with a pending request, grant SHALL occur the same cycle T: mem_en=1 for exactly cycle T, mem_addr/mem_we/mem_wdata driven from the granted requester, state moves to IF_BUSY or DM_BUSY, 4-bit counter loads LATENCY.
REQ-024 Outside a grant cycle mem_en, mem_we SHALL be 0; mem_addr, mem_wdata SHALL hold their last granted values.
REQ-025 Counter SHALL decrement each busy cycle; completion cycle is T+LATENCY.
REQ-026 In the completion cycle the matching ack SHALL be 1; for a fetch or load, the matching rdata SHALL equal mem_rdata in that cycle and be held in a register afterwards until the next completion of the same requester.
REQ-027 Stores SHALL complete with dm_ack in cycle T+LATENCY; dm_rdata unchanged.
REQ-028 State SHALL return to IDLE after the completion cycle; the next grant occurs no earlier than T+LATENCY+1 (no grant in an ack cycle).
REQ-029 Arbitration when both pending in IDLE: data wins unless the previous grant was data, in which case fetch wins (no starvation of either).
REQ-030 Only one pending requester: it SHALL be granted regardless of history.
REQ-031 stall_if SHALL equal if_req AND NOT if_ack; stall_pipe SHALL equal (dm_read OR dm_write) AND NOT dm_ack.
REQ-032 dm_read and dm_write both high at grant: SHALL be treated as a store and set proto_err, which stays 1 until reset.
REQ-033 Request deasserted while its access is busy: access SHALL still complete and ack pulse; no abort.

Reset
REQ-034 reset=1 SHALL immediately force IDLE, counter 0, last-grant = fetch, all outputs 0 (including rdata registers and proto_err), independent of clock.
REQ-035 Reset mid-access SHALL discard the access; no ack is issued for it after reset release.
REQ-036 First grant SHALL be possible in the first rising edge cycle after reset deasserts.

Verification
REQ-037 LATENCY=2, if_req alone, addr 0x40, mem_rdata 0x8C220004 at T+2 -> mem_en at T only, if_ack and if_rdata=0x8C220004 at T+2, stall_if 1 at T..T+1.
REQ-038 if_req and dm_read simultaneous from IDLE, last grant fetch -> data granted at T, fetch granted at T+3; dm_ack T+2, if_ack T+5.
REQ-039 Continuous both requests -> grants alternate data, fetch, data; neither side waits over 2*(LATENCY+1) cycles.
REQ-040 dm_write addr 0x10 data 0xDEADBEEF -> mem_en=1, mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF at T; dm_ack T+2; dm_rdata unchanged.
REQ-041 reset pulsed at T+1 of a load -> all outputs 0 at once, no dm_ack afterward, new grant on first cycle after release.
REQ-042 dm_read and dm_write both high -> store performed, proto_err=1 held until reset.
